// File: rtl/wheel_sensor.sv
`default_nettype none
// ============================================================================
// wheel_sensor - AHB-lite reed-switch debouncer, revolution counter, period timer
// Optional IRQ port with `define WHEEL_IRQ_EN.                       Rev 1.0
// ============================================================================
module wheel_sensor #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PERIOD_W        = 16,
  parameter int COUNT_W         = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic        FORK
`ifdef WHEEL_IRQ_EN
  ,
  output logic        IRQ
`endif
);

  localparam logic [7:0]          DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] PER_MAX = '1;
  localparam logic [PERIOD_W-1:0] PER_ONE = PERIOD_W'(1);
  localparam logic [COUNT_W-1:0]  CNT_ONE = COUNT_W'(1);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_WAIT = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_WAIT = 2'd3
  } db_state_t;

  logic                fork_meta;
  logic                fork_s;
  db_state_t           state;
  db_state_t           state_next;
  logic [7:0]          db_cnt;
  logic [7:0]          db_cnt_next;
  logic                rev_evt;

  logic                addr_phase;
  logic                pend_valid;
  logic                pend_write;
  logic [1:0]          pend_idx;
  logic                clr_count;
  logic                clr_new;

  logic [PERIOD_W-1:0] per_cnt;
  logic [PERIOD_W-1:0] period;
  logic                stopped;
  logic [COUNT_W-1:0]  rev_count;
  logic                new_rev;

  logic                unused_ok;

  assign HREADYOUT = 1'b1;
  assign unused_ok = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA};

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      fork_meta <= 1'b0;
      fork_s    <= 1'b0;
    end else begin
      fork_meta <= FORK;
      fork_s    <= fork_meta;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state  <= ST_LOW;
      db_cnt <= 8'd0;
    end else begin
      state  <= state_next;
      db_cnt <= db_cnt_next;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive stable samples.
  always_comb begin
    state_next  = state;
    db_cnt_next = db_cnt;
    rev_evt     = 1'b0;
    case (state)
      ST_LOW: begin
        if (fork_s) begin
          state_next  = ST_RISE_WAIT;
          db_cnt_next = 8'd0;
        end
      end
      ST_RISE_WAIT: begin
        if (!fork_s) begin
          state_next = ST_LOW;
        end else begin
          db_cnt_next = db_cnt + 8'd1;
          if (db_cnt == DB_LAST) begin
            state_next = ST_HIGH;
            rev_evt    = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (!fork_s) begin
          state_next  = ST_FALL_WAIT;
          db_cnt_next = 8'd0;
        end
      end
      ST_FALL_WAIT: begin
        if (fork_s) begin
          state_next = ST_HIGH;
        end else begin
          db_cnt_next = db_cnt + 8'd1;
          if (db_cnt == DB_LAST) begin
            state_next = ST_LOW;
          end
        end
      end
      default: state_next = ST_LOW;
    endcase
  end

  assign addr_phase = HSEL & HREADY & (HTRANS != 2'b00);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pend_valid <= 1'b0;
      pend_write <= 1'b0;
      pend_idx   <= 2'd0;
    end else begin
      pend_valid <= addr_phase;
      pend_write <= HWRITE;
      pend_idx   <= HADDR[3:2];
    end
  end

  assign clr_count = pend_valid & pend_write & (pend_idx == 2'd0);
  assign clr_new   = pend_valid & pend_write & (pend_idx == 2'd2);

  // A revolution after a stall (or reset) has no valid start point, so it reports max.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      per_cnt <= '0;
      period  <= '0;
      stopped <= 1'b1;
    end else if (rev_evt) begin
      per_cnt <= '0;
      stopped <= 1'b0;
      if (stopped || (per_cnt == PER_MAX)) begin
        period <= PER_MAX;
      end else begin
        period <= per_cnt + PER_ONE;
      end
    end else if (per_cnt == PER_MAX) begin
      stopped <= 1'b1;
    end else begin
      per_cnt <= per_cnt + PER_ONE;
    end
  end

  // A revolution in the same cycle as a software clear is never lost.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rev_count <= '0;
      new_rev   <= 1'b0;
    end else begin
      if (rev_evt) begin
        rev_count <= (clr_count ? '0 : rev_count) + CNT_ONE;
      end else if (clr_count) begin
        rev_count <= '0;
      end
      if (rev_evt) begin
        new_rev <= 1'b1;
      end else if (clr_new) begin
        new_rev <= 1'b0;
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (pend_valid) begin
      case (pend_idx)
        2'd0: HRDATA[COUNT_W-1:0] = rev_count;
        2'd1: begin
          HRDATA[PERIOD_W-1:0] = period;
          HRDATA[31]           = stopped;
        end
        2'd2: HRDATA[0] = new_rev;
        default: HRDATA = '0;
      endcase
    end
  end

`ifdef WHEEL_IRQ_EN
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= new_rev;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wheel_sensor.sv
`default_nettype none
// tb_wheel_sensor - directed and randomized checks of wheel_sensor against a
// cycle-level behavioural model built from run lengths and elapsed-time arithmetic.
module tb_wheel_sensor;

  localparam int D    = 16;
  localparam int PMAX = 65535;
  localparam int CMOD = 65536;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HREADY, HWRITE, FORK, HREADYOUT;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
`ifdef WHEEL_IRQ_EN
  logic        IRQ;
`endif

  always #5 HCLK = ~HCLK;

  wheel_sensor #(.DEBOUNCE_CYCLES(D), .PERIOD_W(16), .COUNT_W(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HWRITE(HWRITE),
    .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE), .HTRANS(HTRANS),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .FORK(FORK)
`ifdef WHEEL_IRQ_EN
    , .IRQ(IRQ)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // model state, valid for the current cycle
  bit     m_s1, m_s2, m_deb, m_stop, m_new, m_irq, m_pv, m_pw;
  int     m_run, m_rev, m_per, m_pi;
  longint cyc = 0;
  longint base = 0;
  logic [31:0] last_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rdata();
    if (!m_pv) return 32'h0;
    case (m_pi)
      0: return 32'(m_rev);
      1: return {m_stop, 15'h0, 16'(m_per)};
      2: return {31'h0, m_new};
      default: return 32'h0;
    endcase
  endfunction

  // true when the next cycle will be a debounced rising event
  function automatic bit evt_next();
    bit deb_n;
    int run_n;
    deb_n = ((m_s2 != m_deb) && (m_run == D + 1)) ? m_s2 : m_deb;
    run_n = (m_s1 == m_s2) ? m_run + 1 : 1;
    return m_s1 && !deb_n && (run_n == D + 1);
  endfunction

  task automatic model_init();
    m_s1 = 0; m_s2 = 0; m_run = 1; m_deb = 0;
    m_rev = 0; m_per = 0; m_stop = 1; m_new = 0; m_irq = 0;
    m_pv = 0; m_pw = 0; m_pi = 0;
    base = cyc;
  endtask

  task automatic model_update();
    bit evt, flip, clr0, clr2;
    longint el;
    evt  = m_s2 && !m_deb && (m_run == D + 1);
    flip = (m_s2 != m_deb) && (m_run == D + 1);
    clr0 = m_pv && m_pw && (m_pi == 0);
    clr2 = m_pv && m_pw && (m_pi == 2);
    el   = cyc - base;
    m_irq = m_new;
    if (evt) begin
      m_per  = m_stop ? PMAX : ((el + 1 > PMAX) ? PMAX : int'(el + 1));
      m_stop = 0;
      base   = cyc + 1;
      m_rev  = ((clr0 ? 0 : m_rev) + 1) % CMOD;
      m_new  = 1;
    end else begin
      if (el >= PMAX) m_stop = 1;
      if (clr0) m_rev = 0;
      if (clr2) m_new = 0;
    end
    if (flip) m_deb = m_s2;
    m_run = (m_s1 == m_s2) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
    m_s2  = m_s1;
    m_s1  = FORK;
    m_pv  = HSEL && HREADY && (HTRANS != 2'b00);
    m_pw  = HWRITE;
    m_pi  = int'(HADDR[3:2]);
    cyc++;
  endtask

  task automatic step_sample();
    @(negedge HCLK);
    if (m_pv) begin
      check_eq("rdata", HRDATA, exp_rdata());
      check_eq("hreadyout", {31'h0, HREADYOUT}, 32'h1);
    end
`ifdef WHEEL_IRQ_EN
    if (m_pv || (cyc % 64 == 0)) check_eq("irq", {31'h0, IRQ}, {31'h0, m_irq});
`endif
    last_rd = HRDATA;
  endtask

  task automatic step_finish();
    model_update();
    @(posedge HCLK);
    #1;
    HWDATA = $urandom();
  endtask

  task automatic step();
    step_sample();
    step_finish();
  endtask

  task automatic hold(input int n, input logic f);
    FORK = f;
    repeat (n) step();
  endtask

  task automatic bus(input bit wr, input int idx, output logic [31:0] rd);
    HSEL = 1; HREADY = 1; HTRANS = 2'b10; HWRITE = wr;
    HADDR = ($urandom() & 32'hFFFF_FFF3) | (32'(idx) << 2);
    step();
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0;
    step();
    rd = last_rd;
  endtask

  task automatic do_reset();
    HRESET = 1; HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HREADY = 1;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check_eq("rst_rdata", HRDATA, 32'h0);
    check_eq("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
`ifdef WHEEL_IRQ_EN
    check_eq("rst_irq", {31'h0, IRQ}, 32'h0);
`endif
    @(posedge HCLK);
    #1;
    HRESET = 0;
    model_init();
  endtask

  task automatic sync_to_event(input string tag);
    int guard;
    FORK = 1;
    guard = 0;
    while (!evt_next() && guard < 100) begin
      step();
      guard++;
    end
    check_eq(tag, {31'h0, guard >= 100}, 32'h0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, rd0;
    int seg;
    HRESET = 1; HSEL = 0; HREADY = 1; HWRITE = 0; HADDR = 0; HWDATA = 0;
    HSIZE = 3'b010; HTRANS = 2'b00; FORK = 0;
    do_reset();

    bus(0, 0, rd); check_eq("t1_rev", rd, 32'h0);
    bus(0, 1, rd); check_eq("t1_period", rd, 32'h8000_0000);
    bus(0, 2, rd); check_eq("t1_new", rd, 32'h0);

    hold(10, 1); hold(40, 0);
    bus(0, 0, rd); check_eq("t2_short_pulse", rd, 32'h0);

    for (int p = 0; p < 3; p++) begin
      hold(40, 1);
      hold(3277 - 40, 0);
    end
    bus(0, 0, rd); check_eq("t3_rev", rd, 32'd3);
    bus(0, 1, rd); check_eq("t3_period", rd, 32'd3277);
    bus(0, 2, rd); check_eq("t3_new", rd, 32'h1);

    bus(0, 0, rd0);
    for (int i = 0; i < 10; i++) hold(3, (i % 2) == 0);
    hold(40, 1); hold(40, 0);
    bus(0, 0, rd); check_eq("t4_one_rev", rd - rd0, 32'h1);

    hold(65540, 0);
    bus(0, 1, rd); check_eq("t5_stopped", {31'h0, rd[31]}, 32'h1);
    hold(40, 1); hold(40, 0);
    bus(0, 1, rd); check_eq("t5_period", rd, 32'h0000_FFFF);

    sync_to_event("t6_sync0_timeout");
    bus(1, 0, rd);
    hold(30, 1); hold(40, 0);
    bus(0, 0, rd); check_eq("t6_rev_evt_wins", rd, 32'h1);

    bus(1, 2, rd);
    bus(0, 2, rd); check_eq("t6_new_cleared_setup", rd, 32'h0);
    sync_to_event("t6_sync2_timeout");
    bus(1, 2, rd);
    hold(30, 1); hold(40, 0);
    bus(0, 2, rd); check_eq("t6_new_evt_wins", rd, 32'h1);

    bus(1, 2, rd);
`ifdef WHEEL_IRQ_EN
    step_sample();
    check_eq("t6_irq_low", {31'h0, IRQ}, 32'h0);
    step_finish();
`endif
    bus(0, 2, rd); check_eq("t6_new_cleared", rd, 32'h0);

    hold(10, 1);
    do_reset();
    hold(30, 1);
    bus(0, 0, rd); check_eq("rst_discard_rev", rd, 32'h1);

    seg = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        FORK = ~FORK;
        seg = FORK ? $urandom_range(1, 40) : $urandom_range(1, 60);
      end
      seg--;
      HSEL   = ($urandom_range(0, 2) == 0);
      HREADY = ($urandom_range(0, 7) != 0);
      HTRANS = 2'($urandom());
      HWRITE = $urandom_range(0, 1) == 1;
      HADDR  = $urandom();
      step();
    end
    HSEL = 0; HTRANS = 2'b00; HREADY = 1; HWRITE = 0;
    hold(40, 0);
    bus(0, 0, rd);
    bus(0, 1, rd);
    bus(0, 2, rd);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
